fadd_share_arbiter: RTL and testbench
=====================================

Name: fadd_share_arbiter

Overview:
- Shares one 2-stage pipelined single-precision adder (`fadd_multi`) among NREQ requesters, for example the FPU issue port and the fsub/fcmp helper path.
- Arbitration is round-robin with valid/ready handshakes. A tag pipeline matched to the adder latency routes each result to a per-requester response FIFO.
- A credit scheme guarantees that no result is ever dropped.
- The block sits between the core FPU dispatch and the shared adder instance.

Parameters:
- NREQ, 2, number of requesters (2..4).
- LAT, 2, adder latency in cycles: a result is present on fadd_y in cycle k+LAT for an operand pair driven in cycle k.
- RBUF, 4, depth of each response FIFO; this is also the maximum number of outstanding ops per requester.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NREQ  request valid, one bit per requester.
- req_ready  out  NREQ  request accepted this cycle (equals grant).
- req_x1  in  32*NREQ  operand 1; requester i uses bits [32i+31:32i].
- req_x2  in  32*NREQ  operand 2, same packing.
- req_sub  in  NREQ  1 = compute x1-x2.
- resp_valid  out  NREQ  response FIFO non-empty.
- resp_ready  in  NREQ  response consumed.
- resp_y  out  32*NREQ  FIFO head, same packing.
- fadd_x1  out  32  to adder x1.
- fadd_x2  out  32  to adder x2.
- fadd_y  in  32  from adder y.
- idle  out  1  no op in flight, all FIFOs empty, all credits zero.

Behaviour:
- Eligibility: requester i is eligible when req_valid[i]=1 and credit[i] < RBUF.
  - credit[i] is a counter of width clog2(RBUF+1).
  - It increments on grant[i] and decrements on resp_valid[i]&&resp_ready[i].
  - On simultaneous grant and pop it stays unchanged.
- Grant: combinational one-hot among eligible requesters.
  - Priority starts at rr_ptr and wraps modulo NREQ.
  - At most one grant per cycle; req_ready = grant.
  - No dependency on resp_ready within the same cycle.
- rr_ptr update: on any grant to i, rr_ptr <= (i+1) mod NREQ; otherwise it holds.
- Operand drive:
  - With a grant: fadd_x1 = x1 of the granted requester; fadd_x2 = x2 with bit 31 inverted when req_sub=1.
  - Without a grant: both are 32'h0.
- Tag pipeline: LAT stages of {vld, id}.
  - Stage 0 captures {|grant, index of the granted requester}.
  - Each stage shifts every cycle; there is no stall.
  - When the output of stage LAT-1 has vld=1 in cycle c, fadd_y is written into FIFO[id] at the end of cycle c.
  - Minimum request-to-resp_valid latency is LAT+1 cycles: handshake in cycle k gives resp_valid in cycle k+LAT+1.
- Response FIFOs: one per requester, depth RBUF, first-word fall-through.
  - Write and pop in the same cycle are both honoured.
  - The credit rule guarantees a write never hits a full FIFO.
  - resp_y holds the head entry while resp_valid=1 and is don't-care when empty.
  - Ordering per requester is preserved.
  - Interleaving across requesters follows issue order.
- Full/credit boundary: with credit[i]=RBUF, req_ready[i]=0 even if the adder is free. Other requesters are still granted.
- Reset:
  - Asserting rst in any cycle, including with ops in flight, has the following effect on the next edge: tag vlds cleared (in-flight ops discarded), FIFOs emptied, credits 0, rr_ptr 0.
  - While rst=1: req_ready=0, resp_valid=0, fadd_x1=fadd_x2=0, idle=1.
  - The adder instance is driven with rstn=~rst by the parent.
- The block does not inspect or alter results: no NaN/overflow handling, no rounding changes.

Test Plan:
- Single op: req0 x1=3F800000, x2=40000000, sub=0 issued in cycle 10 -> resp_valid[0]=1 in cycle 13 with resp_y0=40400000; idle returns to 1 after the pop.
- Subtract: req1 x1=40400000, x2=3F800000, sub=1 -> fadd_x2=BF800000 in the grant cycle; resp_y1=40000000.
- Contention: both valid continuously with resp_ready=1 -> grants alternate 0,1,0,1 starting with requester 0 after reset; one op per cycle; results in per-requester order.
- Backpressure: resp_ready[0]=0 with req0 streaming -> exactly 4 grants to req0, then req_ready[0]=0. req1 keeps being granted every cycle. Releasing resp_ready[0] pops 4 correct results in order, then issue resumes.
- Same-cycle events: credit[0]=4, pop and req0 valid in the same cycle -> no grant that cycle (credit still 4 at evaluation). Grant in the next cycle; credit ends at 4.
- Reset mid-flight: 2 ops in flight plus 1 buffered result, rst high for 1 cycle -> no resp_valid ever appears for them. Credits 0, idle=1, and the next grant goes to requester 0.

Source files
------------

// File: rtl/fadd_share_arbiter.sv
// fadd_share_arbiter
// Shares one pipelined single-precision adder (latency LAT) among NREQ
// requesters. Round-robin grant, a tag pipeline that follows the adder, and
// one first-word-fall-through response FIFO per requester. A requester only
// issues while it holds fewer than RBUF outstanding ops, so every result has
// a guaranteed FIFO slot and nothing is ever dropped.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   req_valid/ready        per-requester issue handshake (ready == grant)
//   req_x1/x2/sub          operands, 32 bits per requester, sub flips x2 sign
//   resp_valid/ready/y     per-requester response FIFO head
//   fadd_x1/x2, fadd_y     to/from the shared adder
//   idle                   nothing in flight, FIFOs empty, credits zero
module fadd_share_arbiter #(
    parameter int NREQ = 2,
    parameter int LAT  = 2,
    parameter int RBUF = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_x1,
    input  logic [32*NREQ-1:0]   req_x2,
    input  logic [NREQ-1:0]      req_sub,
    output logic [NREQ-1:0]      resp_valid,
    input  logic [NREQ-1:0]      resp_ready,
    output logic [32*NREQ-1:0]   resp_y,
    output logic [31:0]          fadd_x1,
    output logic [31:0]          fadd_x2,
    input  logic [31:0]          fadd_y,
    output logic                 idle
);
    localparam int CW = $clog2(RBUF + 1);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int PW = (RBUF > 1) ? $clog2(RBUF) : 1;

    logic [NREQ-1:0][CW-1:0] credit_q, credit_d;
    logic [NREQ-1:0][CW-1:0] cnt_q, cnt_d;
    logic [NREQ-1:0][PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [NREQ-1:0][PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]             mem_q [NREQ][RBUF];
    logic [31:0]             mem_d [NREQ][RBUF];
    logic [IW-1:0]           rr_ptr_q, rr_ptr_d;
    logic [LAT-1:0]          tag_vld_q, tag_vld_d;
    logic [LAT-1:0][IW-1:0]  tag_id_q, tag_id_d;

    logic [NREQ-1:0] elig, grant, wr_en, pop;
    logic [IW-1:0]   gnt_id;
    logic [IW:0]     scan;
    logic            found;

    function automatic logic [PW-1:0] nxt_ptr(input logic [PW-1:0] p);
        return (p == PW'(RBUF - 1)) ? '0 : p + PW'(1);
    endfunction

    // Eligibility ignores resp_ready on purpose: a pop this cycle only frees
    // a credit for the next cycle, keeping the grant path short.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NREQ; i++) begin
            elig[i] = !rst && req_valid[i] && (credit_q[i] < CW'(RBUF));
        end
    end

    // Round-robin scan starting at rr_ptr, wrapping modulo NREQ.
    always_comb begin
        grant  = '0;
        gnt_id = '0;
        found  = 1'b0;
        scan   = '0;
        for (int o = 0; o < NREQ; o++) begin
            scan = {1'b0, rr_ptr_q} + (IW+1)'(o);
            if (scan >= (IW+1)'(NREQ)) scan = scan - (IW+1)'(NREQ);
            if (!found && elig[scan[IW-1:0]]) begin
                grant[scan[IW-1:0]] = 1'b1;
                gnt_id              = scan[IW-1:0];
                found               = 1'b1;
            end
        end
    end

    assign req_ready = grant;

    always_comb begin
        fadd_x1 = 32'h0;
        fadd_x2 = 32'h0;
        if (found) begin
            fadd_x1 = req_x1[32*gnt_id +: 32];
            fadd_x2 = req_x2[32*gnt_id +: 32] ^ {req_sub[gnt_id], 31'b0};
        end
    end

    // The last tag stage lines up with fadd_y for the same op.
    always_comb begin
        resp_valid = '0;
        resp_y     = '0;
        wr_en      = '0;
        pop        = '0;
        for (int i = 0; i < NREQ; i++) begin
            resp_valid[i]       = !rst && (cnt_q[i] != '0);
            resp_y[32*i +: 32]  = mem_q[i][rd_ptr_q[i]];
            wr_en[i]            = tag_vld_q[LAT-1] && (tag_id_q[LAT-1] == IW'(i));
            pop[i]              = resp_valid[i] && resp_ready[i];
        end
    end

    assign idle = rst || ((tag_vld_q == '0) && (cnt_q == '0) && (credit_q == '0));

    always_comb begin
        credit_d = credit_q;
        cnt_d    = cnt_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        mem_d    = mem_q;
        rr_ptr_d = rr_ptr_q;
        if (found) rr_ptr_d = (gnt_id == IW'(NREQ - 1)) ? '0 : gnt_id + IW'(1);

        tag_vld_d    = tag_vld_q;
        tag_id_d     = tag_id_q;
        tag_vld_d[0] = found;
        tag_id_d[0]  = gnt_id;
        for (int s = 1; s < LAT; s++) begin
            tag_vld_d[s] = tag_vld_q[s-1];
            tag_id_d[s]  = tag_id_q[s-1];
        end

        for (int i = 0; i < NREQ; i++) begin
            case ({grant[i], pop[i]})
                2'b10:   credit_d[i] = credit_q[i] + CW'(1);
                2'b01:   credit_d[i] = credit_q[i] - CW'(1);
                default: credit_d[i] = credit_q[i];
            endcase
            case ({wr_en[i], pop[i]})
                2'b10:   cnt_d[i] = cnt_q[i] + CW'(1);
                2'b01:   cnt_d[i] = cnt_q[i] - CW'(1);
                default: cnt_d[i] = cnt_q[i];
            endcase
            if (wr_en[i]) begin
                mem_d[i][wr_ptr_q[i]] = fadd_y;
                wr_ptr_d[i]           = nxt_ptr(wr_ptr_q[i]);
            end
            if (pop[i]) rd_ptr_d[i] = nxt_ptr(rd_ptr_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            credit_q  <= '0;
            cnt_q     <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            rr_ptr_q  <= '0;
            tag_vld_q <= '0;
            tag_id_q  <= '0;
        end else begin
            credit_q  <= credit_d;
            cnt_q     <= cnt_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            rr_ptr_q  <= rr_ptr_d;
            tag_vld_q <= tag_vld_d;
            tag_id_q  <= tag_id_d;
        end
    end

    // Storage needs no reset: contents are only visible behind cnt_q.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: tb/tb_fadd_share_arbiter.sv
module tb_fadd_share_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid, req_ready, req_sub, resp_valid, resp_ready;
    logic [63:0] req_x1, req_x2, resp_y;
    logic [31:0] fadd_x1, fadd_x2, fadd_y;
    logic        idle;

    int n_chk = 0;
    int n_fail = 0;
    int opn = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] a_s1, a_s2;

    always #5 clk = ~clk;

    fadd_share_arbiter #(.NREQ(2), .LAT(2), .RBUF(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x1(req_x1), .req_x2(req_x2), .req_sub(req_sub),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_y(resp_y),
        .fadd_x1(fadd_x1), .fadd_x2(fadd_x2), .fadd_y(fadd_y),
        .idle(idle)
    );

    // Stand-in adder: exact for the float cases the bench names, integer
    // sum otherwise (the block never looks at result contents).
    function automatic logic [31:0] fake_add(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        if (a == 32'h40400000 && b == 32'hBF800000) return 32'h40000000;
        return a + b;
    endfunction

    always @(posedge clk) begin
        a_s1 <= fake_add(fadd_x1, fadd_x2);
        a_s2 <= a_s1;
    end
    assign fadd_y = a_s2;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_check(input string nm);
        logic [31:0] e;
        if (resp_valid[0] && resp_ready[0]) begin
            if (q0.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL %s_unexp0: got %h, expected no response", nm, resp_y[31:0]);
            end else begin
                e = q0.pop_front();
                chk({nm, "_y0"}, resp_y[31:0], e);
            end
        end
        if (resp_valid[1] && resp_ready[1]) begin
            if (q1.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL %s_unexp1: got %h, expected no response", nm, resp_y[63:32]);
            end else begin
                e = q1.pop_front();
                chk({nm, "_y1"}, resp_y[63:32], e);
            end
        end
    endtask

    // One cycle of streaming traffic: req1 always subtracts.
    task automatic cyc(input logic [1:0] v, input logic [1:0] rr, input logic [1:0] eg, input string nm);
        logic [31:0] a0, a1;
        opn++;
        a0 = 32'h1000_0000 + opn;
        a1 = 32'h2000_0000 + opn;
        req_valid = v; resp_ready = rr;
        req_x1 = {a1, a0}; req_x2 = {32'h2, 32'h1}; req_sub = 2'b10;
        #2;
        chk({nm, "_grant"}, {30'b0, req_ready}, {30'b0, eg});
        if (eg[0]) begin
            chk({nm, "_fx1"}, fadd_x1, a0);
            chk({nm, "_fx2"}, fadd_x2, 32'h1);
            q0.push_back(fake_add(a0, 32'h1));
        end
        if (eg[1]) begin
            chk({nm, "_fx1"}, fadd_x1, a1);
            chk({nm, "_fx2"}, fadd_x2, 32'h8000_0002);
            q1.push_back(fake_add(a1, 32'h8000_0002));
        end
        pop_check(nm);
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = 2'b00; resp_ready = 2'b00;
        tick();
        rst = 1'b0;
        q0.delete(); q1.delete();
    endtask

    task automatic drained(input string nm);
        chk({nm, "_q0_left"}, q0.size(), 0);
        chk({nm, "_q1_left"}, q1.size(), 0);
        #2;
        chk({nm, "_idle"}, {31'b0, idle}, 32'h1);
    endtask

    typedef struct {
        int          id;
        logic [31:0] x1;
        logic [31:0] x2;
        logic        sub;
        logic [31:0] exp_fx2;
        logic [31:0] exp_y;
    } vec_t;

    vec_t vecs[4];
    logic [1:0] bp_eg[16];

    initial begin
        vecs[0] = '{0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40000000, 32'h40400000};
        vecs[1] = '{1, 32'h40400000, 32'h3F800000, 1'b1, 32'hBF800000, 32'h40000000};
        vecs[2] = '{1, 32'h12345678, 32'h11111111, 1'b0, 32'h11111111, 32'h23456789};
        vecs[3] = '{0, 32'h80000001, 32'h00000002, 1'b1, 32'h80000002, 32'h00000003};
        // Hand-derived grant trace: req0 fills its 4 credits while
        // alternating, then req1 alone; release at cycle 12 (credit still 4).
        bp_eg = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10,
                  2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01};

        rst = 1'b1; req_valid = 2'b11; resp_ready = 2'b00;
        req_x1 = {32'h5, 32'h7}; req_x2 = {32'h1, 32'h1}; req_sub = 2'b00;
        repeat (2) tick();
        #2;
        chk("rst_ready", {30'b0, req_ready}, 32'h0);
        chk("rst_resp_valid", {30'b0, resp_valid}, 32'h0);
        chk("rst_fx1", fadd_x1, 32'h0);
        chk("rst_fx2", fadd_x2, 32'h0);
        chk("rst_idle", {31'b0, idle}, 32'h1);
        tick();
        do_reset();

        // Single ops from idle, table-driven.
        for (int t = 0; t < 4; t++) begin
            logic [1:0] m;
            m = 2'b00; m[vecs[t].id] = 1'b1;
            req_valid = m; resp_ready = 2'b00;
            req_x1 = '0; req_x2 = '0; req_sub = '0;
            req_x1[32*vecs[t].id +: 32] = vecs[t].x1;
            req_x2[32*vecs[t].id +: 32] = vecs[t].x2;
            req_sub[vecs[t].id] = vecs[t].sub;
            #2;
            chk("tbl_ready", {30'b0, req_ready}, {30'b0, m});
            chk("tbl_fx1", fadd_x1, vecs[t].x1);
            chk("tbl_fx2", fadd_x2, vecs[t].exp_fx2);
            tick();
            req_valid = 2'b00;
            #2;
            chk("tbl_bus_quiet", fadd_x1, 32'h0);
            chk("tbl_lat1", {30'b0, resp_valid}, 32'h0);
            tick(); #2;
            chk("tbl_lat2", {30'b0, resp_valid}, 32'h0);
            tick(); #2;
            chk("tbl_lat3", {30'b0, resp_valid}, {30'b0, m});
            chk("tbl_y", resp_y[32*vecs[t].id +: 32], vecs[t].exp_y);
            chk("tbl_busy", {31'b0, idle}, 32'h0);
            resp_ready = m;
            tick();
            resp_ready = 2'b00;
            #2;
            chk("tbl_popped", {30'b0, resp_valid}, 32'h0);
            chk("tbl_idle", {31'b0, idle}, 32'h1);
            tick();
        end

        // Contention: alternate from requester 0 after reset.
        do_reset();
        for (int c = 0; c < 8; c++) cyc(2'b11, 2'b11, (c % 2 == 0) ? 2'b01 : 2'b10, "cont");
        for (int c = 0; c < 6; c++) cyc(2'b00, 2'b11, 2'b00, "cont_drain");
        drained("cont");

        // Backpressure on requester 0.
        do_reset();
        for (int c = 0; c < 16; c++) cyc(2'b11, (c < 12) ? 2'b10 : 2'b11, bp_eg[c], "bp");
        for (int c = 0; c < 8; c++) cyc(2'b00, 2'b11, 2'b00, "bp_drain");
        drained("bp");

        // Pop and request in the same cycle at full credit.
        do_reset();
        for (int c = 0; c < 4; c++) cyc(2'b01, 2'b00, 2'b01, "same_fill");
        for (int c = 0; c < 3; c++) cyc(2'b01, 2'b00, 2'b00, "same_full");
        cyc(2'b01, 2'b01, 2'b00, "same_pop");
        cyc(2'b01, 2'b00, 2'b01, "same_next");
        cyc(2'b01, 2'b00, 2'b00, "same_refull");
        for (int c = 0; c < 10; c++) cyc(2'b00, 2'b01, 2'b00, "same_drain");
        drained("same");

        // Reset with one buffered result and two ops in the adder.
        do_reset();
        cyc(2'b01, 2'b00, 2'b01, "mid_a");
        cyc(2'b00, 2'b00, 2'b00, "mid_w");
        cyc(2'b00, 2'b00, 2'b00, "mid_w");
        cyc(2'b10, 2'b00, 2'b10, "mid_b");
        cyc(2'b01, 2'b00, 2'b01, "mid_c");
        q0.delete(); q1.delete();
        rst = 1'b1; req_valid = 2'b11; resp_ready = 2'b11;
        #2;
        chk("mid_rst_ready", {30'b0, req_ready}, 32'h0);
        chk("mid_rst_resp", {30'b0, resp_valid}, 32'h0);
        chk("mid_rst_fx1", fadd_x1, 32'h0);
        chk("mid_rst_idle", {31'b0, idle}, 32'h1);
        tick();
        rst = 1'b0; req_valid = 2'b00;
        #2;
        chk("mid_post_idle", {31'b0, idle}, 32'h1);
        chk("mid_post_resp", {30'b0, resp_valid}, 32'h0);
        tick();
        cyc(2'b11, 2'b11, 2'b01, "mid_next");
        for (int c = 0; c < 6; c++) cyc(2'b00, 2'b11, 2'b00, "mid_drain");
        drained("mid");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
